rdata_collector: RTL and testbench

- Return-path counterpart of the host-to-DRAM instruction/write-data merger.
- Snoops the read beats issued by each dispatched instruction and captures 512-bit read data from the PHY, which arrives valid-only with no backpressure.
- Buffers the data in a FIFO and streams it back to the host as an AXI Stream master, packetised with TLAST.
- Tracks outstanding reads and flags overflow and unexpected data.

---
 rtl/rdata_collector_pkg.sv | 15 +
 rtl/rdata_collector_fifo.sv | 42 ++++
 rtl/rdata_collector.sv | 99 +++++++++
 tb/tb_rdata_collector.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdata_collector_pkg.sv
// Shared DDR command definitions and read-return defaults.
package rdata_collector_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_WR  = 3'd4,
    CMD_RD  = 3'd5
  } ddr_cmd_e;

  localparam int CMD_SLOT_WIDTH   = 32;
  localparam int SLOTS_PER_INSTR  = 4;
  localparam int RDATA_WIDTH_DEF  = 512;
  localparam int RD_ISSUE_CNT_W   = 3;

endpackage

// File: rtl/rdata_collector_fifo.sv
// First-word fall-through synchronous FIFO; pointers carry one extra wrap bit.
module sync_fifo_fwft #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rdata_collector.sv
// Captures PHY read beats into a FIFO and streams them to the host as
// TLAST-framed packets, tracking outstanding reads and drop/unexpected status.
module rdata_collector
  import rdata_collector_pkg::*;
#(
  parameter int RDATA_WIDTH    = RDATA_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 16,
  parameter int PKT_BEATS      = 8,
  parameter int OUTST_WIDTH    = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_issue_valid,
  input  logic [RD_ISSUE_CNT_W-1:0]     rd_issue_cnt,
  input  logic [RDATA_WIDTH-1:0]        phy_rdata,
  input  logic                          phy_rdata_valid,
  output logic [RDATA_WIDTH-1:0]        M_AXIS_RDATA_TDATA,
  output logic                          M_AXIS_RDATA_TVALID,
  input  logic                          M_AXIS_RDATA_TREADY,
  output logic                          M_AXIS_RDATA_TLAST,
  input  logic                          clear_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          unexpected_rdata,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  output logic                          idle
);

  localparam int BCW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      unexpected;
  logic [RD_ISSUE_CNT_W-1:0] issue_inc;
  logic [BCW-1:0]            beat_cnt;
  logic [OUTST_WIDTH-1:0]    outst;
  logic [OUTST_WIDTH:0]      outst_sum;
  logic [OUTST_WIDTH-1:0]    outst_next;

  sync_fifo_fwft #(
    .WIDTH (RDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (phy_rdata),
    .pop   (pop),
    .rdata (M_AXIS_RDATA_TDATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pop        = M_AXIS_RDATA_TVALID && M_AXIS_RDATA_TREADY;
  // A pop frees the slot this same edge, so a full FIFO can still take the beat.
  assign push       = phy_rdata_valid && (!fifo_full || pop);
  assign drop       = phy_rdata_valid && fifo_full && !pop;
  assign issue_inc  = rd_issue_valid ? rd_issue_cnt : '0;
  assign unexpected = phy_rdata_valid && (outst == '0) && (issue_inc == '0);

  assign M_AXIS_RDATA_TVALID = !fifo_empty;
  assign M_AXIS_RDATA_TLAST  = M_AXIS_RDATA_TVALID && (beat_cnt == BCW'(PKT_BEATS - 1));
  assign idle                = (outst == '0) && fifo_empty;

  // Issue and beat net out first; the beat only decrements a nonzero total.
  always_comb begin
    outst_sum = {1'b0, outst} + (OUTST_WIDTH+1)'(issue_inc);
    if (phy_rdata_valid && (outst_sum != '0)) outst_sum = outst_sum - (OUTST_WIDTH+1)'(1);
    outst_next = outst_sum[OUTST_WIDTH] ? '1 : outst_sum[OUTST_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt         <= '0;
      outst            <= '0;
      overflow         <= 1'b0;
      unexpected_rdata <= 1'b0;
      drop_count       <= '0;
    end else begin
      if (pop) beat_cnt <= M_AXIS_RDATA_TLAST ? '0 : beat_cnt + BCW'(1);
      outst <= outst_next;

      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;

      if (unexpected)        unexpected_rdata <= 1'b1;
      else if (clear_status) unexpected_rdata <= 1'b0;

      if (clear_status)                     drop_count <= drop ? DROP_CNT_WIDTH'(1) : '0;
      else if (drop && (drop_count != '1))  drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rdata_collector.sv
// Bench for rdata_collector: directed scenarios plus a randomized run against a queue model.
module tb_rdata_collector;

  localparam int W     = 512;
  localparam int DEPTH = 16;
  localparam int PKT   = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd_issue_valid = 1'b0;
  logic [2:0]     rd_issue_cnt = 3'd0;
  logic [W-1:0]   phy_rdata = '0;
  logic           phy_rdata_valid = 1'b0;
  logic [W-1:0]   tdata;
  logic           tvalid;
  logic           tready = 1'b0;
  logic           tlast;
  logic           clear_status = 1'b0;
  logic [4:0]     fifo_level;
  logic           overflow;
  logic           unexpected_rdata;
  logic [15:0]    drop_count;
  logic           idle;

  always #5 clk = ~clk;

  rdata_collector #(
    .RDATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .PKT_BEATS(PKT),
    .OUTST_WIDTH(16), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_issue_valid(rd_issue_valid), .rd_issue_cnt(rd_issue_cnt),
    .phy_rdata(phy_rdata), .phy_rdata_valid(phy_rdata_valid),
    .M_AXIS_RDATA_TDATA(tdata), .M_AXIS_RDATA_TVALID(tvalid),
    .M_AXIS_RDATA_TREADY(tready), .M_AXIS_RDATA_TLAST(tlast),
    .clear_status(clear_status), .fifo_level(fifo_level),
    .overflow(overflow), .unexpected_rdata(unexpected_rdata),
    .drop_count(drop_count), .idle(idle)
  );

  // Reference model: a queue of buffered beats plus counters.
  logic [W-1:0] mq[$];
  int m_popped, m_outst, m_drops;
  bit m_ovf, m_unexp;
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [W-1:0] pat(int i);
    logic [31:0] w;
    w = 32'h5000_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    bit pop, full, push, drop;
    int inc;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); m_popped = 0; m_outst = 0; m_drops = 0; m_ovf = 0; m_unexp = 0;
    end else begin
      pop  = (mq.size() > 0) && tready;
      full = (mq.size() == DEPTH);
      push = phy_rdata_valid && (!full || pop);
      drop = phy_rdata_valid && full && !pop;
      inc  = rd_issue_valid ? int'(rd_issue_cnt) : 0;
      if (pop) begin void'(mq.pop_front()); m_popped++; end
      if (push) mq.push_back(phy_rdata);
      if (clear_status) begin m_ovf = 0; m_unexp = 0; m_drops = 0; end
      if (drop) begin m_ovf = 1; if (m_drops < 65535) m_drops++; end
      if (phy_rdata_valid && m_outst == 0 && inc == 0) m_unexp = 1;
      m_outst = m_outst + inc - (phy_rdata_valid ? 1 : 0);
      if (m_outst < 0) m_outst = 0;
    end
    #1;
  endtask

  task automatic quiet_inputs();
    rd_issue_valid = 0; rd_issue_cnt = 0; phy_rdata_valid = 0;
    tready = 0; clear_status = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 7;
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    if (tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast got %b want 0", tlast); end
    if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (unexpected_rdata !== 1'b0) begin tests_failed++; $display("FAIL reset_unexp got %b want 0", unexpected_rdata); end
    if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drops got %0d want 0", drop_count); end
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle got %b want 1", idle); end
  endtask

  task automatic test_single_read();
    logic [31:0] a5 = 32'hA5A5_A5A5;
    do_reset();
    rd_issue_valid = 1; rd_issue_cnt = 1; tick();
    rd_issue_valid = 0;
    phy_rdata = {16{a5}}; phy_rdata_valid = 1; tready = 1; tick();
    phy_rdata_valid = 0;
    tests_run += 4;
    if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL single_tvalid got %b want 1", tvalid); end
    if (tdata !== {16{a5}}) begin tests_failed++; $display("FAIL single_tdata got %h want %h", tdata, {16{a5}}); end
    if (tlast !== 1'b0) begin tests_failed++; $display("FAIL single_tlast got %b want 0", tlast); end
    if (idle !== 1'b0) begin tests_failed++; $display("FAIL single_busy got %b want 0", idle); end
    tick();
    tests_run += 2;
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle got %b want 1", idle); end
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL single_drained got %b want 0", tvalid); end
  endtask

  task automatic test_packetisation();
    int got = 0;
    do_reset();
    tready = 1;
    rd_issue_valid = 1; rd_issue_cnt = 4;
    for (int i = 0; i < 4; i++) tick();
    rd_issue_valid = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      phy_rdata_valid = (c < 16); phy_rdata = pat(c);
      tick();
      if (tvalid) begin
        tests_run++;
        if (tdata !== pat(got) || tlast !== ((got % PKT) == PKT - 1)) begin
          tests_failed++;
          $display("FAIL pkt_beat%0d got data %h last %b want data %h last %b",
                   got, tdata[31:0], tlast, pat(got) & 32'hFFFF_FFFF, ((got % PKT) == PKT - 1));
        end
        got++;
      end
    end
    phy_rdata_valid = 0;
    tick();
    tests_run += 3;
    if (got != 16) begin tests_failed++; $display("FAIL pkt_count got %0d want 16", got); end
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL pkt_idle got %b want 1", idle); end
    if (unexpected_rdata !== 1'b0) begin tests_failed++; $display("FAIL pkt_unexp got %b want 0", unexpected_rdata); end
  endtask

  task automatic test_overflow();
    int got = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rd_issue_valid = (i < 5); rd_issue_cnt = 4;
      phy_rdata_valid = 1; phy_rdata = pat(i);
      tick();
    end
    quiet_inputs();
    tests_run += 3;
    if (fifo_level !== 5'd16) begin tests_failed++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
    if (drop_count !== 16'd2) begin tests_failed++; $display("FAIL ovf_drops got %0d want 2", drop_count); end
    tready = 1;
    for (int c = 0; c < 40 && tvalid; c++) begin
      tests_run++;
      if (tdata !== pat(got) || tlast !== ((got % PKT) == PKT - 1)) begin
        tests_failed++;
        $display("FAIL ovf_drain%0d got %h last %b want %h", got, tdata[31:0], tlast, pat(got) & 32'hFFFF_FFFF);
      end
      got++;
      tick();
    end
    tests_run++;
    if (got != 16) begin tests_failed++; $display("FAIL ovf_drain_count got %0d want 16", got); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rd_issue_valid = (i == 0); rd_issue_cnt = 4;
      phy_rdata_valid = 1; phy_rdata = pat(i);
      tick();
    end
    rd_issue_valid = 0;
    tests_run++;
    if (fifo_level !== 5'd16) begin tests_failed++; $display("FAIL fullpop_fill got %0d want 16", fifo_level); end
    phy_rdata = pat(100); tready = 1; tick();
    phy_rdata_valid = 0; tready = 0;
    tests_run += 3;
    if (fifo_level !== 5'd16) begin tests_failed++; $display("FAIL fullpop_level got %0d want 16", fifo_level); end
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
    if (tdata !== pat(1)) begin tests_failed++; $display("FAIL fullpop_head got %h want %h", tdata[31:0], pat(1) & 32'hFFFF_FFFF); end
    tready = 1;
    for (int i = 0; i < 15; i++) tick();
    tests_run++;
    if (tdata !== pat(100)) begin tests_failed++; $display("FAIL fullpop_tail got %h want %h", tdata[31:0], pat(100) & 32'hFFFF_FFFF); end
  endtask

  task automatic test_unexpected();
    logic [W-1:0] b;
    do_reset();
    b = rand_beat();
    phy_rdata = b; phy_rdata_valid = 1; tick();
    phy_rdata_valid = 0;
    tests_run += 3;
    if (unexpected_rdata !== 1'b1) begin tests_failed++; $display("FAIL unexp_set got %b want 1", unexpected_rdata); end
    if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL unexp_delivered got %b want 1", tvalid); end
    if (tdata !== b) begin tests_failed++; $display("FAIL unexp_data got %h want %h", tdata[31:0], b[31:0]); end
    clear_status = 1; phy_rdata_valid = 1; tick();
    phy_rdata_valid = 0;
    tests_run++;
    if (unexpected_rdata !== 1'b1) begin tests_failed++; $display("FAIL unexp_set_wins got %b want 1", unexpected_rdata); end
    tick();
    clear_status = 0;
    tests_run += 2;
    if (unexpected_rdata !== 1'b0) begin tests_failed++; $display("FAIL unexp_clear got %b want 0", unexpected_rdata); end
    if (idle !== 1'b0) begin tests_failed++; $display("FAIL unexp_fifo_busy got %b want 0", idle); end
  endtask

  task automatic test_reset_mid_packet();
    int got = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rd_issue_valid = (i == 0); rd_issue_cnt = 4;
      phy_rdata_valid = 1; phy_rdata = pat(i);
      tick();
    end
    quiet_inputs();
    tready = 1;
    for (int i = 0; i < 3; i++) tick();
    tready = 0;
    tests_run++;
    if (fifo_level !== 5'd5) begin tests_failed++; $display("FAIL mid_level got %0d want 5", fifo_level); end
    rst_n = 0; tick(); rst_n = 1;
    tests_run += 3;
    if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_tvalid got %b want 0", tvalid); end
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_idle got %b want 1", idle); end
    tready = 1;
    for (int c = 0; c < 30 && got < 8; c++) begin
      rd_issue_valid = (c < 2); rd_issue_cnt = 4;
      phy_rdata_valid = (c < 8); phy_rdata = pat(200 + c);
      tick();
      if (tvalid) begin
        tests_run++;
        if (tlast !== (got == 7) || tdata !== pat(200 + got)) begin
          tests_failed++;
          $display("FAIL mid_pkt_beat%0d got last %b data %h want last %b", got, tlast, tdata[31:0], (got == 7));
        end
        got++;
      end
    end
    quiet_inputs();
    tick();
    tests_run++;
    if (got != 8) begin tests_failed++; $display("FAIL mid_pkt_count got %0d want 8", got); end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy_pct = ((cyc / 200) % 2 == 1) ? 15 : 85;
      rd_issue_valid  = ($urandom_range(0, 99) < 20);
      rd_issue_cnt    = 3'($urandom_range(0, 4));
      phy_rdata_valid = ($urandom_range(0, 99) < 55);
      phy_rdata       = rand_beat();
      tready          = ($urandom_range(0, 99) < rdy_pct);
      clear_status    = ($urandom_range(0, 99) < 3);
      tick();
      tests_run += 7;
      if (tvalid !== (mq.size() > 0)) begin tests_failed++; $display("FAIL rnd_tvalid cyc %0d got %b want %b", cyc, tvalid, mq.size() > 0); end
      if (mq.size() > 0) begin
        tests_run++;
        if (tdata !== mq[0]) begin tests_failed++; $display("FAIL rnd_tdata cyc %0d got %h want %h", cyc, tdata[31:0], mq[0][31:0]); end
      end
      if (tlast !== ((mq.size() > 0) && (m_popped % PKT == PKT - 1))) begin
        tests_failed++; $display("FAIL rnd_tlast cyc %0d got %b popped %0d", cyc, tlast, m_popped);
      end
      if (fifo_level !== 5'(mq.size())) begin tests_failed++; $display("FAIL rnd_level cyc %0d got %0d want %0d", cyc, fifo_level, mq.size()); end
      if (overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd_overflow cyc %0d got %b want %b", cyc, overflow, m_ovf); end
      if (unexpected_rdata !== m_unexp) begin tests_failed++; $display("FAIL rnd_unexp cyc %0d got %b want %b", cyc, unexpected_rdata, m_unexp); end
      if (drop_count !== 16'(m_drops)) begin tests_failed++; $display("FAIL rnd_drops cyc %0d got %0d want %0d", cyc, drop_count, m_drops); end
      if (idle !== (m_outst == 0 && mq.size() == 0)) begin
        tests_failed++; $display("FAIL rnd_idle cyc %0d got %b outst %0d level %0d", cyc, idle, m_outst, mq.size());
      end
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_packetisation();
    test_overflow();
    test_full_pop();
    test_unexpected();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
